// File: rtl/booth_pp_if.sv
// Row-in / product-out bus for booth_pp_accumulator.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid may not depend on ready.
interface booth_pp_if #(
    parameter int LANES  = 16,
    parameter int SLOT_W = 24,
    parameter int NSLOT  = 4
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [LANES-1:0][NSLOT*SLOT_W-1:0]   pp_in;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [LANES-1:0][SLOT_W-1:0]         prod_out;

    modport master (
        output in_valid, pp_in, out_ready,
        input  in_ready, out_valid, prod_out
    );

    modport slave (
        input  in_valid, pp_in, out_ready,
        output in_ready, out_valid, prod_out
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sums NSLOT signed partial-product slots per lane, one slot per cycle, each shifted SHIFT*k bits.
// All lanes share one FSM and slot counter; results are truncated to SLOT_W bits.
module booth_pp_accumulator #(
    parameter int LANES  = 16,
    parameter int SLOT_W = 24,
    parameter int NSLOT  = 4,
    parameter int SHIFT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    booth_pp_if.slave   bus,
    output logic        busy,
    output logic [15:0] done_cnt,
    output logic [1:0]  dbg_state_o
);
    localparam int CNT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NSLOT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                             state_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic [LANES-1:0][NSLOT*SLOT_W-1:0] row_q;
    logic [LANES-1:0][SLOT_W-1:0]       acc_q;
    logic [LANES-1:0][SLOT_W-1:0]       acc_d;
    logic [LANES-1:0][SLOT_W-1:0]       slot_sel;
    logic [15:0]                        done_cnt_q;
    logic                               in_ready_q;
    logic                               out_valid_q;
    logic                               busy_q;

    // Slot and accumulator share one width, so sign extension is implicit and
    // the shifted add wraps modulo 2^SLOT_W by construction.
    always_comb begin
        acc_d    = acc_q;
        slot_sel = '0;
        for (int l = 0; l < LANES; l++) begin
            slot_sel[l] = row_q[l][int'(cnt_q)*SLOT_W +: SLOT_W];
            acc_d[l]    = acc_q[l] + (slot_sel[l] << (SHIFT * int'(cnt_q)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            done_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        row_q      <= bus.pp_in;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_SLOT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low on this edge, so a row cannot slip in alongside the handshake.
                    if (bus.out_ready && out_valid_q) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        done_cnt_q  <= done_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.prod_out  = acc_q;
    assign busy          = busy_q;
    assign done_cnt      = done_cnt_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator with hand-computed expected products.
module tb_booth_pp_accumulator;
    localparam int LANES  = 16;
    localparam int SLOT_W = 24;
    localparam int NSLOT  = 4;
    localparam int SHIFT  = 3;

    typedef logic [LANES-1:0][NSLOT*SLOT_W-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] done_cnt;
    logic [1:0]  dbg_state;

    booth_pp_if #(.LANES(LANES), .SLOT_W(SLOT_W), .NSLOT(NSLOT)) bus ();

    booth_pp_accumulator #(
        .LANES(LANES), .SLOT_W(SLOT_W), .NSLOT(NSLOT), .SHIFT(SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .done_cnt    (done_cnt),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int                n_tests  = 0;
    int                n_fail   = 0;
    int                exp_done = 0;
    logic [SLOT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_all(input logic [SLOT_W-1:0] v);
        for (int l = 0; l < LANES; l++) exp_q.push_back(v);
    endtask

    task automatic scramble_inputs();
        bus.in_valid = 1'($urandom_range(0, 1));
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < NSLOT; k++)
                bus.pp_in[l][k*SLOT_W +: SLOT_W] = SLOT_W'($urandom());
    endtask

    task automatic run_txn(input row_t row, input int hold, input bit noise);
        int lat;
        logic [LANES-1:0][SLOT_W-1:0] snap;
        logic [SLOT_W-1:0] e;
        bus.pp_in     = row;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_in_accum", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (noise) scramble_inputs();
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(NSLOT));
        for (int l = 0; l < LANES; l++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check($sformatf("prod_lane%0d", l), 32'(bus.prod_out[l]), 32'(e));
        end
        snap = bus.prod_out;
        for (int h = 0; h < hold; h++) begin
            if (noise) scramble_inputs();
            tick();
            check("prod_stable", 32'(bus.prod_out == snap), 32'd1);
            check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
            check("out_valid_held", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = noise;
        tick();
        bus.out_ready = 1'b0;
        exp_done      = (exp_done + 1) % 65536;
        check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
        check("busy_after_hs", 32'(busy), 32'd0);
        check("done_cnt", 32'(done_cnt), 32'(exp_done));
        bus.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    row_t row;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pp_in     = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_prod_zero", 32'(bus.prod_out == '0), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // Abort in the middle of accumulation
        row = '0;
        row[0][0 +: SLOT_W] = 24'h000408;
        bus.pp_in    = row;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_prod_zero", 32'(bus.prod_out == '0), 32'd1);
        tick();
        rst_n = 1'b1;

        // Single lane, slot0 only, out_ready already high
        row = '0;
        row[0][0 +: SLOT_W] = 24'h000408;
        exp_q.push_back(24'h000408);
        for (int l = 1; l < LANES; l++) exp_q.push_back(24'h000000);
        run_txn(row, 0, 1'b0);

        // -1 + (1 << 3) = 7 on every lane
        row = '0;
        for (int l = 0; l < LANES; l++) begin
            row[l][0*SLOT_W +: SLOT_W] = 24'hFFFFFF;
            row[l][1*SLOT_W +: SLOT_W] = 24'h000001;
        end
        push_all(24'h000007);
        run_txn(row, 0, 1'b0);

        // 0x7FFFFF << 9 truncated to 24 bits
        row = '0;
        for (int l = 0; l < LANES; l++) row[l][3*SLOT_W +: SLOT_W] = 24'h7FFFFF;
        push_all(24'hFFFE00);
        run_txn(row, 2, 1'b0);

        // Lane-distinct: l + 8 - 64 + 512 = 0x1C8 + l
        row = '0;
        for (int l = 0; l < LANES; l++) begin
            row[l][0*SLOT_W +: SLOT_W] = SLOT_W'(l);
            row[l][1*SLOT_W +: SLOT_W] = 24'h000001;
            row[l][2*SLOT_W +: SLOT_W] = 24'hFFFFFF;
            row[l][3*SLOT_W +: SLOT_W] = 24'h000001;
            exp_q.push_back(SLOT_W'(32'h1C8 + l));
        end
        run_txn(row, 1, 1'b0);

        // Backpressure with noisy input: 0x123456 + 0x80 + 0x80 = 0x123556
        row = '0;
        for (int l = 0; l < LANES; l++) begin
            row[l][0*SLOT_W +: SLOT_W] = 24'h123456;
            row[l][1*SLOT_W +: SLOT_W] = 24'h000010;
            row[l][2*SLOT_W +: SLOT_W] = 24'h000002;
        end
        push_all(24'h123556);
        run_txn(row, 5, 1'b1);

        // Back-to-back reuse of the same row
        for (int t = 0; t < 3; t++) begin
            push_all(24'h123556);
            run_txn(row, 0, 1'b0);
        end

        // Preset the completion counter near its top, then cross the wrap
        force dut.done_cnt_q = 16'hFFFE;
        #1;
        release dut.done_cnt_q;
        exp_done = 65534;
        push_all(24'h123556);
        run_txn(row, 0, 1'b0);
        push_all(24'h123556);
        run_txn(row, 1, 1'b0);
        check("done_cnt_wrapped", 32'(done_cnt), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
